// File: rtl/eq_pkg.sv
// Shared types, defaults and arithmetic helpers for the EQ band scheduler.
// Saturation works on a 64-bit signed value so any DATA_W up to 63 can reuse it.
package eq_pkg;

  localparam int NBANDS_DEF = 8;
  localparam int GAIN_W_DEF = 4;
  localparam int DATA_W_DEF = 24;
  localparam int UNITY_GAIN = 1 << (GAIN_W_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // Sum of NBANDS products of width dw+gw+1 needs clog2(nb) guard bits.
  function automatic int acc_width(input int dw, input int gw, input int nb);
    return dw + gw + 1 + $clog2(nb);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/eq_gain_regs.sv
// Shadow/active gain double buffer; active only changes when apply_i is high.
// A load coinciding with apply_i goes straight to active so that sample sees it.
module eq_gain_regs
  import eq_pkg::*;
#(
  parameter int NBANDS = NBANDS_DEF,
  parameter int GAIN_W = GAIN_W_DEF
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     cfg_load_i,
  input  logic [NBANDS*GAIN_W-1:0] eq_vals_i,
  input  logic                     apply_i,
  output logic [NBANDS*GAIN_W-1:0] active_o
);

  localparam int CFG_W = NBANDS * GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << (GAIN_W - 1));
  localparam logic [CFG_W-1:0] UNITY_ALL = {NBANDS{UNITY}};

  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] active_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_q <= UNITY_ALL;
      active_q <= UNITY_ALL;
    end else begin
      if (cfg_load_i) shadow_q <= eq_vals_i;
      if (apply_i)    active_q <= cfg_load_i ? eq_vals_i : shadow_q;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/eq_band_sched.sv
// Shares one band MAC across all (channel, band) jobs of a stereo sample, accumulating
// and saturating per channel; new samples arriving while busy are dropped and flagged.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int NBANDS = NBANDS_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       newsample,
  input  logic [DATA_W-1:0]          left,
  input  logic [DATA_W-1:0]          right,
  input  logic                       cfg_load,
  input  logic [NBANDS*GAIN_W-1:0]   eq_vals,
  output logic                       mac_start,
  output logic                       mac_ch,
  output logic [$clog2(NBANDS)-1:0]  mac_band,
  output logic [GAIN_W-1:0]          mac_gain,
  output logic [DATA_W-1:0]          mac_din,
  input  logic                       mac_done,
  input  logic [DATA_W+GAIN_W:0]     mac_result,
  output logic [DATA_W-1:0]          out_left,
  output logic [DATA_W-1:0]          out_right,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int BAND_W = $clog2(NBANDS);
  localparam int JOB_W  = BAND_W + 1;
  localparam int RES_W  = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = acc_width(DATA_W, GAIN_W, NBANDS);
  localparam int CFG_W  = NBANDS * GAIN_W;

  state_e                    state_q, state_d;
  logic [JOB_W-1:0]          job_q, job_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         res_l_q, res_l_d;
  logic [DATA_W-1:0]         res_r_q, res_r_d;
  logic [DATA_W-1:0]         smp_l_q, smp_r_q;
  logic [DATA_W-1:0]         out_left_q, out_right_q;
  logic                      out_valid_q, overrun_q;

  logic [CFG_W-1:0]          gains_act;
  logic [GAIN_W-1:0]         gain_arr [NBANDS];
  logic                      accept, idle;
  logic                      cur_ch;
  logic [BAND_W-1:0]         cur_band;
  logic [GAIN_W-1:0]         cur_gain;
  logic [DATA_W-1:0]         cur_din;
  logic                      last_band, last_job;
  logic signed [ACC_W-1:0]   mac_ext, acc_sum;
  logic signed [63:0]        acc_wide, acc_shift;
  logic [DATA_W-1:0]         ch_sat;
  logic                      job_end;

  assign idle   = (state_q == ST_IDLE);
  assign accept = newsample && idle;

  eq_gain_regs #(.NBANDS(NBANDS), .GAIN_W(GAIN_W)) u_gain_regs (
    .clk        (clk),
    .nreset     (nreset),
    .cfg_load_i (cfg_load),
    .eq_vals_i  (eq_vals),
    .apply_i    (accept),
    .active_o   (gains_act)
  );

  always_comb begin
    for (int b = 0; b < NBANDS; b++) gain_arr[b] = gains_act[GAIN_W*b +: GAIN_W];
  end

  // Job index j: upper bit selects the channel, lower bits the band.
  assign cur_ch    = job_q[BAND_W];
  assign cur_band  = job_q[BAND_W-1:0];
  assign cur_gain  = gain_arr[cur_band];
  assign cur_din   = cur_ch ? smp_r_q : smp_l_q;
  assign last_band = (cur_band == BAND_W'(NBANDS - 1));
  assign last_job  = (job_q == JOB_W'(2 * NBANDS - 1));

  // A skipped job contributes nothing; only WAIT adds the MAC product.
  assign mac_ext   = {{(ACC_W-RES_W){mac_result[RES_W-1]}}, mac_result};
  assign acc_sum   = acc_q + ((state_q == ST_WAIT) ? mac_ext : '0);
  assign acc_wide  = {{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
  assign acc_shift = acc_wide >>> (GAIN_W - 1);
  assign ch_sat    = DATA_W'(saturate(acc_shift, DATA_W));

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    acc_d     = acc_q;
    res_l_d   = res_l_q;
    res_r_d   = res_r_q;
    mac_start = 1'b0;
    job_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (newsample) begin
          job_d   = '0;
          acc_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_gain == '0) begin
          job_end = 1'b1;
        end else begin
          mac_start = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mac_done) job_end = 1'b1;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (job_end) begin
      if (last_band) begin
        acc_d = '0;
        if (cur_ch) res_r_d = ch_sat;
        else        res_l_d = ch_sat;
      end else begin
        acc_d = acc_sum;
      end
      if (last_job) begin
        state_d = ST_FINISH;
      end else begin
        job_d   = job_q + JOB_W'(1);
        state_d = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      job_q       <= '0;
      acc_q       <= '0;
      res_l_q     <= '0;
      res_r_q     <= '0;
      smp_l_q     <= '0;
      smp_r_q     <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      acc_q       <= acc_d;
      res_l_q     <= res_l_d;
      res_r_q     <= res_r_d;
      out_valid_q <= (state_q == ST_FINISH);
      if (accept) begin
        smp_l_q <= left;
        smp_r_q <= right;
      end
      if (state_q == ST_FINISH) begin
        out_left_q  <= res_l_q;
        out_right_q <= res_r_q;
      end
      if (newsample && !idle) overrun_q <= 1'b1;
    end
  end

  // Job fields read as zero while idle; stable from ISSUE through mac_done.
  assign mac_ch    = idle ? 1'b0 : cur_ch;
  assign mac_band  = idle ? '0 : cur_band;
  assign mac_gain  = idle ? '0 : cur_gain;
  assign mac_din   = idle ? '0 : cur_din;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign busy      = !idle;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_band_sched.sv
// Directed bench for eq_band_sched with a fixed-latency MAC model (done 3 cycles after start).
module tb_eq_band_sched;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        nreset, newsample, cfg_load, mac_done;
  logic [23:0] left, right, mac_din, out_left, out_right;
  logic [31:0] eq_vals;
  logic        mac_start, mac_ch, out_valid, busy, overrun;
  logic [2:0]  mac_band;
  logic [3:0]  mac_gain;
  logic [28:0] mac_result;

  eq_band_sched dut (
    .clk(clk), .nreset(nreset), .newsample(newsample), .left(left), .right(right),
    .cfg_load(cfg_load), .eq_vals(eq_vals), .mac_start(mac_start), .mac_ch(mac_ch),
    .mac_band(mac_band), .mac_gain(mac_gain), .mac_din(mac_din), .mac_done(mac_done),
    .mac_result(mac_result), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // MAC model: returns din*gain L cycles after each start; records every launch.
  int          mac_cnt = 0;
  int          ov_cnt = 0;
  logic [31:0] starts[$];
  logic [23:0] pend_din;
  logic [3:0]  pend_gain;
  longint      prod;

  always @(negedge clk) begin
    mac_done = 1'b0;
    if (mac_cnt > 0) begin
      mac_cnt--;
      if (mac_cnt == 0) begin
        prod       = longint'($signed(pend_din)) * longint'(pend_gain);
        mac_result = prod[28:0];
        mac_done   = 1'b1;
      end
    end
    if (mac_start) begin
      starts.push_back({mac_ch, mac_band, mac_gain, mac_din});
      mac_cnt   = L;
      pend_din  = mac_din;
      pend_gain = mac_gain;
    end
    if (out_valid) ov_cnt++;
  end

  task automatic run_sample(input logic [23:0] l, input logic [23:0] r,
                            input logic cfg_en, input logic [31:0] cfg_v,
                            input int inj_ns, input int inj_cfg_at, input logic [31:0] inj_cfg_v,
                            output int lat);
    starts.delete();
    @(negedge clk);
    left = l; right = r; newsample = 1'b1; cfg_load = cfg_en;
    if (cfg_en) eq_vals = cfg_v;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      newsample = 1'b0;
      cfg_load  = 1'b0;
      if (n == inj_ns) newsample = 1'b1;
      if (n == inj_cfg_at) begin
        cfg_load = 1'b1;
        eq_vals  = inj_cfg_v;
      end
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    newsample = 1'b0;
    cfg_load  = 1'b0;
  endtask

  task automatic expect_starts(input string tag, input logic [31:0] g,
                               input logic [23:0] l, input logic [23:0] r);
    logic [31:0] exp_q[$];
    logic [31:0] gv;
    logic [3:0]  gb;
    gv = g;
    for (int j = 0; j < 16; j++) begin
      gb = gv[4*(j%8) +: 4];
      if (gb != 4'd0) exp_q.push_back({1'(j / 8), 3'(j % 8), gb, (j < 8) ? l : r});
    end
    check({tag, "_nstart"}, 64'(starts.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < starts.size(); i++)
      check($sformatf("%s_job%0d", tag, i), starts[i], exp_q[i]);
  endtask

  task automatic pulse_cfg(input logic [31:0] v);
    @(negedge clk);
    cfg_load = 1'b1; eq_vals = v;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  int lat;

  initial begin
    nreset = 1'b0; newsample = 1'b0; cfg_load = 1'b0; mac_done = 1'b0;
    left = '0; right = '0; eq_vals = '0; mac_result = '0;
    repeat (3) @(negedge clk);
    check("rst_out_left", out_left, 0);
    check("rst_out_right", out_right, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mac", {mac_start, mac_ch, mac_band, mac_gain, mac_din}, 0);
    nreset = 1'b1;

    // Default unity gains: 8 bands x unity = 8x input.
    run_sample(24'h001000, 24'hFFF000, 0, 0, 0, 0, 0, lat);
    expect_starts("unity", 32'h88888888, 24'h001000, 24'hFFF000);
    check("unity_lat", lat, 66);
    check("unity_left", out_left, 24'h008000);
    check("unity_right", out_right, 24'hFF8000);

    // Band 0 only: two launches, 7 skips per channel.
    pulse_cfg(32'h00000008);
    run_sample(24'h123456, 24'h000010, 0, 0, 0, 0, 0, lat);
    expect_starts("band0", 32'h00000008, 24'h123456, 24'h000010);
    check("band0_lat", lat, 24);
    check("band0_left", out_left, 24'h123456);
    check("band0_right", out_right, 24'h000010);

    // Max gain via same-cycle bypass, saturating both directions.
    run_sample(24'h7FFFFF, 24'h800000, 1, 32'hFFFFFFFF, 0, 0, 0, lat);
    expect_starts("max", 32'hFFFFFFFF, 24'h7FFFFF, 24'h800000);
    check("max_lat", lat, 66);
    check("sat_pos_left", out_left, 24'h7FFFFF);
    check("sat_neg_right", out_right, 24'h800000);
    run_sample(24'h800000, 24'h7FFFFF, 0, 0, 0, 0, 0, lat);
    check("sat_neg_left", out_left, 24'h800000);
    check("sat_pos_right", out_right, 24'h7FFFFF);

    // Mid-job mute load only takes effect on the following sample.
    run_sample(24'h001000, 24'hFFF000, 0, 0, 0, 10, 32'h0, lat);
    expect_starts("oldg", 32'hFFFFFFFF, 24'h001000, 24'hFFF000);
    check("oldg_left", out_left, 24'h00F000);
    check("oldg_right", out_right, 24'hFF1000);
    run_sample(24'h001000, 24'hFFF000, 0, 0, 0, 0, 0, lat);
    check("mute_nstart", 64'(starts.size()), 0);
    check("mute_lat", lat, 18);
    check("mute_left", out_left, 0);
    check("mute_right", out_right, 0);

    // Second newsample during job 5 is dropped and flagged.
    pulse_cfg(32'h88888888);
    check("ovr_pre", overrun, 0);
    ov_cnt = 0;
    run_sample(24'h000100, 24'h000200, 0, 0, 21, 0, 0, lat);
    expect_starts("ovr", 32'h88888888, 24'h000100, 24'h000200);
    check("ovr_lat", lat, 66);
    check("ovr_left", out_left, 24'h000800);
    check("ovr_right", out_right, 24'h001000);
    check("ovr_flag", overrun, 1);
    repeat (80) @(negedge clk);
    check("ovr_one_valid", 64'(ov_cnt), 1);
    check("ovr_sticky", overrun, 1);
    check("ovr_idle", busy, 0);

    // Reset while waiting on the MAC, then a stray done arrives.
    @(negedge clk);
    left = 24'h000400; right = 24'h000300; newsample = 1'b1;
    @(negedge clk);
    newsample = 1'b0;
    check("rstj_start", mac_start, 1);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("rstj_busy", busy, 0);
    check("rstj_outs", {out_left, out_right, out_valid, overrun}, 0);
    check("rstj_mac", {mac_start, mac_ch, mac_band, mac_gain, mac_din}, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    #1;
    check("stray_done", mac_done, 1);
    @(negedge clk);
    #1;
    check("stray_state", {busy, mac_start, out_valid}, 0);
    run_sample(24'h000400, 24'h000300, 0, 0, 0, 0, 0, lat);
    expect_starts("post", 32'h88888888, 24'h000400, 24'h000300);
    check("post_lat", lat, 66);
    check("post_left", out_left, 24'h002000);
    check("post_right", out_right, 24'h001800);
    check("post_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eq_band_sched.md
Name: eq_band_sched

Overview:
- Per-sample scheduler that shares one band-filter MAC engine across all EQ bands and both stereo channels.
- Sits between the I2S receiver (left/right/newsample) and the output path.
- Takes 32-bit gain words from the SPI block, double-buffers them, and applies them only on sample boundaries.
- Issues one MAC job per (channel, band), sums the results with saturation, and emits one processed stereo sample.

Parameters:
- NBANDS, 8, number of EQ bands; NBANDS*GAIN_W must equal 32.
- GAIN_W, 4, gain code width per band; unsigned; code 2^(GAIN_W-1)=8 is unity.
- DATA_W, 24, audio sample width, signed two's complement.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- newsample  in  1  one-cycle pulse; left/right valid
- left  in  DATA_W  left input sample
- right  in  DATA_W  right input sample
- cfg_load  in  1  one-cycle pulse, already synchronous to clk; eq_vals valid
- eq_vals  in  32  band gains; band b = eq_vals[GAIN_W*b +: GAIN_W]
- mac_start  out  1  one-cycle job launch
- mac_ch  out  1  0=left, 1=right
- mac_band  out  clog2(NBANDS)  band index
- mac_gain  out  GAIN_W  gain code for the job
- mac_din  out  DATA_W  latched channel sample
- mac_done  in  1  one-cycle pulse; mac_result valid
- mac_result  in  DATA_W+GAIN_W+1  signed band output times gain
- out_left  out  DATA_W  processed left sample
- out_right  out  DATA_W  processed right sample
- out_valid  out  1  one-cycle pulse; outputs updated
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; newsample arrived while busy

Behaviour:
- Reset (async, nreset=0): all outputs 0; state IDLE; shadow and active gains all = unity (8); accumulator 0.
- Config: cfg_load captures eq_vals into the shadow register in any state.
  - Shadow is copied to active only in IDLE, in the same cycle newsample is accepted.
  - cfg_load and newsample in the same cycle: the new eq_vals is used for that sample (shadow bypass).
- States: IDLE, ISSUE, WAIT, FINISH.
  - IDLE:
    - On newsample: latch left and right; load active gains; job index j=0 (channel = j/NBANDS, band = j%NBANDS); clear accumulator.
    - Go to ISSUE.
  - ISSUE:
    - If the job's gain code is 0: no MAC launch (skip). Increment j, or go to FINISH at the last job. One cycle.
    - Otherwise: mac_start=1 for exactly one cycle, with mac_ch/mac_band/mac_gain/mac_din valid. Go to WAIT.
    - mac_ch/mac_band/mac_gain/mac_din are held stable until mac_done.
  - WAIT:
    - On mac_done: add sign-extended mac_result to the accumulator.
    - If the last job of the channel, store the channel result and clear the accumulator.
    - Next job goes to ISSUE; after the last job, go to FINISH.
    - mac_done outside WAIT is ignored.
  - FINISH: out_valid=1 for one cycle, out_left/out_right updated simultaneously; go to IDLE.
- Job order: left bands 0..NBANDS-1, then right bands 0..NBANDS-1.
- Arithmetic:
  - Accumulator width DATA_W+GAIN_W+1+clog2(NBANDS); cannot overflow.
  - Channel result = acc >>> (GAIN_W-1) (arithmetic shift), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - All bands muted: output 0.
- Latency, with MAC done L cycles after start and no skips: newsample to out_valid = 1 + 2*NBANDS*(L+1) + 1 cycles.
- Overrun:
  - newsample while busy=1: sample dropped; overrun set and held until reset.
  - The current sample continues unaffected.
  - newsample in the FINISH cycle also counts as an overrun.
- out_left/out_right hold their values between out_valid pulses.
- Reset mid-job: immediate return to IDLE and reset values; any later mac_done is ignored.

Decomposition:
- eq_pkg:
  - state enum (IDLE, ISSUE, WAIT, FINISH)
  - NBANDS/GAIN_W/DATA_W defaults
  - UNITY_GAIN constant
  - accumulator width function
  - saturate function
- One sub-module: eq_gain_regs (shadow/active double buffer with bypass).
- Sequencing and accumulation stay in eq_band_sched.

Test Plan:
- Reset, then no cfg_load; left=0x001000, right=0xFFF000; model MAC returns din*gain after L=3.
  - Required: 16 mac_start pulses in order L0..L7, R0..R7, each with gain=8.
  - Required: out_left=0x008000 and out_right=0xFF8000 (8 bands × unity); out_valid exactly 66 cycles after newsample.
- cfg_load eq_vals=0x00000008 (band0 unity, others muted), then newsample left=0x123456.
  - Required: only 2 mac_start (L0, R0); out_left=0x123456.
- eq_vals=0xFFFFFFFF, left=0x7FFFFF.
  - Required: out_left saturates to 0x7FFFFF; left=0x800000 gives 0x800000.
- cfg_load pulsed mid-job with 0x00000000.
  - Required: the current sample uses the old gains; the next sample issues zero MAC jobs; outputs 0; out_valid 2+16 cycles after newsample.
- Second newsample at job 5.
  - Required: overrun=1 and stays set; first sample completes correctly; no extra out_valid.
- nreset low during WAIT, then a stray mac_done.
  - Required: all outputs 0 and busy=0; stray mac_done causes no state change; the next newsample processes normally.
